tlb_translate_stage: RTL and testbench

Two-stage virtual-to-physical address translation stage that sits directly upstream of the TLB array. It accepts virtual address requests from the fetch or memory pipeline and drives `tlb_params::search_request_t` into the TLB. It consumes the combinational `search_result_t`, then returns a registered physical address, cacheability attribute and TLB exception code. Unmapped segments (kseg0/kseg1) bypass the TLB.

---
 rtl/tlb_translate_stage.sv | 193 +++++++++++++++++++
 tb/tb_tlb_translate_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_translate_stage.sv
// -----------------------------------------------------------------------------
// tlb_params
//   Shared types for the TLB search interface.
//   search_request_t : virtual page number (VA[31:13]), even/odd page select,
//                      and the ASID to match.
//   search_result_t  : hit flag, index of the hit entry and the selected page.
// -----------------------------------------------------------------------------
package tlb_params;
  localparam int TLB_NUM = 16;
  localparam int IDX_W   = $clog2(TLB_NUM);

  typedef struct packed {
    logic [18:0] virtual_page_number;
    logic        is_even_page;
    logic [7:0]  asid;
  } search_request_t;

  typedef struct packed {
    logic [19:0] page_frame_number;
    logic [2:0]  is_cached;
    logic        is_dirty;
    logic        is_valid;
  } tlb_entry_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    tlb_entry_t       entry;
  } search_result_t;
endpackage

// -----------------------------------------------------------------------------
// tlb_translate_stage
//   Two-stage virtual-to-physical translation in front of the TLB array.
//   S1 holds the accepted request and drives search_request; the TLB answers
//   combinationally on search_result. S2 holds the translated response.
//   kseg0/kseg1 (VA[31:29] = 100/101) bypass the TLB.
//
//   Ports
//     clock, reset_n         : clock, asynchronous active-low reset
//     flush                  : drops everything in flight, blocks acceptance
//     req_valid/req_ready    : request handshake
//     req_vaddr/is_store/asid: request payload
//     search_request         : S1 lookup request to the TLB
//     search_result          : TLB answer for search_request (same cycle)
//     resp_valid/resp_ready  : response handshake
//     resp_paddr, resp_cached, resp_exc, resp_bad_vaddr, resp_tlb_index
//                            : registered response (exc: 0 none, 1 refill,
//                              2 invalid, 3 modified)
// -----------------------------------------------------------------------------
module tlb_translate_stage
  import tlb_params::*;
#(
  parameter int TLB_NUM = tlb_params::TLB_NUM
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_vaddr,
  input  logic                       req_is_store,
  input  logic [7:0]                 req_asid,
  output search_request_t            search_request,
  input  search_result_t             search_result,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [31:0]                resp_paddr,
  output logic [2:0]                 resp_cached,
  output logic [1:0]                 resp_exc,
  output logic [31:0]                resp_bad_vaddr,
  output logic [$clog2(TLB_NUM)-1:0] resp_tlb_index
);

  localparam int RIDX_W = $clog2(TLB_NUM);

  // S1 state
  logic              s1_valid_reg;
  logic [31:0]       s1_vaddr_reg;
  logic              s1_is_store_reg;
  logic [7:0]        s1_asid_reg;
  // Kept as its own flop so search_request is all-zero out of reset
  // (deriving it from ~vaddr[12] would read 1 after reset).
  logic              s1_even_reg;

  // S2 state
  logic              s2_valid_reg;
  logic [31:0]       s2_paddr_reg;
  logic [2:0]        s2_cached_reg;
  logic [1:0]        s2_exc_reg;
  logic [31:0]       s2_bad_vaddr_reg;
  logic [RIDX_W-1:0] s2_index_reg;

  // Translation of the S1 entry
  logic [31:0]       paddr_next;
  logic [2:0]        cached_next;
  logic [1:0]        exc_next;
  logic [RIDX_W-1:0] index_next;

  logic s1_advance;
  logic req_fire;

  assign s1_advance = s1_valid_reg && (!s2_valid_reg || resp_ready);
  assign req_ready  = !flush && (!s1_valid_reg || s1_advance);
  assign req_fire   = req_valid && req_ready;

  assign search_request.virtual_page_number = s1_vaddr_reg[31:13];
  assign search_request.is_even_page        = s1_even_reg;
  assign search_request.asid                = s1_asid_reg;

  always_comb begin
    paddr_next  = '0;
    cached_next = '0;
    exc_next    = 2'd0;
    index_next  = '0;
    if (s1_vaddr_reg[31:30] == 2'b10) begin
      // kseg0 (bit 29 = 0) is cached, kseg1 (bit 29 = 1) is uncached
      paddr_next  = {3'b000, s1_vaddr_reg[28:0]};
      cached_next = s1_vaddr_reg[29] ? 3'd2 : 3'd3;
    end else begin
      if (search_result.found) begin
        index_next = RIDX_W'(search_result.index);
      end
      if (!search_result.found) begin
        exc_next = 2'd1;
      end else if (!search_result.entry.is_valid) begin
        exc_next = 2'd2;
      end else if (s1_is_store_reg && !search_result.entry.is_dirty) begin
        exc_next = 2'd3;
      end else begin
        paddr_next  = {search_result.entry.page_frame_number, s1_vaddr_reg[11:0]};
        cached_next = search_result.entry.is_cached;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg     <= 1'b0;
      s1_vaddr_reg     <= '0;
      s1_is_store_reg  <= 1'b0;
      s1_asid_reg      <= '0;
      s1_even_reg      <= 1'b0;
      s2_valid_reg     <= 1'b0;
      s2_paddr_reg     <= '0;
      s2_cached_reg    <= '0;
      s2_exc_reg       <= '0;
      s2_bad_vaddr_reg <= '0;
      s2_index_reg     <= '0;
    end else begin
      if (flush) begin
        s1_valid_reg <= 1'b0;
      end else if (req_fire) begin
        s1_valid_reg <= 1'b1;
      end else if (s1_advance) begin
        s1_valid_reg <= 1'b0;
      end

      if (req_fire) begin
        s1_vaddr_reg    <= req_vaddr;
        s1_is_store_reg <= req_is_store;
        s1_asid_reg     <= req_asid;
        s1_even_reg     <= ~req_vaddr[12];
      end

      if (flush) begin
        s2_valid_reg <= 1'b0;
      end else if (s1_advance) begin
        s2_valid_reg <= 1'b1;
      end else if (resp_ready) begin
        s2_valid_reg <= 1'b0;
      end

      // search_result is sampled only at the advancing edge, so a TLB
      // write that lands while S1 is stalled is seen by that request.
      if (s1_advance) begin
        s2_paddr_reg     <= paddr_next;
        s2_cached_reg    <= cached_next;
        s2_exc_reg       <= exc_next;
        s2_bad_vaddr_reg <= s1_vaddr_reg;
        s2_index_reg     <= index_next;
      end
    end
  end

  assign resp_valid     = s2_valid_reg;
  assign resp_paddr     = s2_paddr_reg;
  assign resp_cached    = s2_cached_reg;
  assign resp_exc       = s2_exc_reg;
  assign resp_bad_vaddr = s2_bad_vaddr_reg;
  assign resp_tlb_index = s2_index_reg;

endmodule

// File: tb/tb_tlb_translate_stage.sv
module tb_tlb_translate_stage;
  import tlb_params::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_vaddr = '0;
  logic        req_is_store = 1'b0;
  logic [7:0]  req_asid = '0;
  search_request_t search_request;
  search_result_t  search_result;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_paddr;
  logic [2:0]  resp_cached;
  logic [1:0]  resp_exc;
  logic [31:0] resp_bad_vaddr;
  logic [IDX_W-1:0] resp_tlb_index;

  int checks = 0;
  int failures = 0;

  tlb_translate_stage #(.TLB_NUM(TLB_NUM)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vaddr      (req_vaddr),
    .req_is_store   (req_is_store),
    .req_asid       (req_asid),
    .search_request (search_request),
    .search_result  (search_result),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_paddr     (resp_paddr),
    .resp_cached    (resp_cached),
    .resp_exc       (resp_exc),
    .resp_bad_vaddr (resp_bad_vaddr),
    .resp_tlb_index (resp_tlb_index)
  );

  always #5 clock = ~clock;

  // ---------------- TLB array stand-in ----------------
  typedef struct packed {
    logic             present;
    logic [18:0]      vpn;
    logic [7:0]       asid;
    tlb_entry_t [1:0] page;   // page[0] even, page[1] odd
  } tb_ent_t;

  tb_ent_t tbl [TLB_NUM];

  always_comb begin
    search_result = '0;
    for (int i = TLB_NUM - 1; i >= 0; i--) begin
      if (tbl[i].present && tbl[i].vpn == search_request.virtual_page_number &&
          tbl[i].asid == search_request.asid) begin
        search_result.found = 1'b1;
        search_result.index = IDX_W'(i);
        search_result.entry = tbl[i].page[search_request.is_even_page ? 0 : 1];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0]      paddr;
    logic [2:0]       cached;
    logic [1:0]       exc;
    logic [31:0]      bad;
    logic [IDX_W-1:0] idx;
  } exp_t;

  function automatic exp_t model_xlate(logic [31:0] va, logic st, logic [7:0] asid);
    exp_t r;
    int hit;
    tlb_entry_t e;
    r = '0;
    r.bad = va;
    hit = -1;
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
      r.paddr = va - 32'h8000_0000;
      r.cached = 3'd3;
      return r;
    end
    if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
      r.paddr = va - 32'hA000_0000;
      r.cached = 3'd2;
      return r;
    end
    for (int i = 0; i < TLB_NUM; i++) begin
      if (hit < 0 && tbl[i].present && tbl[i].vpn == va[31:13] && tbl[i].asid == asid) hit = i;
    end
    if (hit < 0) begin
      r.exc = 2'd1;
      return r;
    end
    r.idx = IDX_W'(hit);
    e = tbl[hit].page[va[12]];
    if (!e.is_valid) r.exc = 2'd2;
    else if (st && !e.is_dirty) r.exc = 2'd3;
    else begin
      r.paddr = (32'(e.page_frame_number) << 12) | (va & 32'h0000_0FFF);
      r.cached = e.is_cached;
    end
    return r;
  endfunction

  logic            m_s1_valid = 1'b0;
  logic [31:0]     m_s1_vaddr = '0;
  logic            m_s1_store = 1'b0;
  logic [7:0]      m_s1_asid = '0;
  search_request_t m_sreq = '0;
  logic            m_out_valid = 1'b0;
  exp_t            m_out = '0;
  logic            m_adv, m_rdy;

  assign m_adv = m_s1_valid && (!m_out_valid || resp_ready);
  assign m_rdy = !flush && (!m_s1_valid || m_adv);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1_valid  <= 1'b0;
      m_s1_vaddr  <= '0;
      m_s1_store  <= 1'b0;
      m_s1_asid   <= '0;
      m_sreq      <= '0;
      m_out_valid <= 1'b0;
      m_out       <= '0;
    end else begin
      if (m_adv) m_out <= model_xlate(m_s1_vaddr, m_s1_store, m_s1_asid);
      if (flush) m_out_valid <= 1'b0;
      else if (m_adv) m_out_valid <= 1'b1;
      else if (resp_ready) m_out_valid <= 1'b0;
      if (m_rdy && req_valid) begin
        m_s1_vaddr <= req_vaddr;
        m_s1_store <= req_is_store;
        m_s1_asid  <= req_asid;
        m_sreq     <= '{virtual_page_number: req_vaddr[31:13],
                        is_even_page: ~req_vaddr[12], asid: req_asid};
      end
      if (flush) m_s1_valid <= 1'b0;
      else if (m_rdy && req_valid) m_s1_valid <= 1'b1;
      else if (m_adv) m_s1_valid <= 1'b0;
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid low phase.
  always @(negedge clock) begin
    #2;
    check("m_resp_valid", 64'(resp_valid), 64'(m_out_valid));
    check("m_req_ready", 64'(req_ready), 64'(m_rdy));
    check("m_search_request", 64'(search_request), 64'(m_sreq));
    if (m_out_valid || !reset_n) begin
      check("m_paddr", 64'(resp_paddr), 64'(m_out.paddr));
      check("m_cached", 64'(resp_cached), 64'(m_out.cached));
      check("m_exc", 64'(resp_exc), 64'(m_out.exc));
      check("m_bad_vaddr", 64'(resp_bad_vaddr), 64'(m_out.bad));
      check("m_tlb_index", 64'(resp_tlb_index), 64'(m_out.idx));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic drive(logic v, logic [31:0] va, logic st, logic [7:0] asid);
    req_valid = v;
    req_vaddr = va;
    req_is_store = st;
    req_asid = asid;
  endtask

  task automatic send_one(string name, logic [31:0] va, logic st, logic [7:0] asid,
                          logic [31:0] e_paddr, logic [2:0] e_cached, logic [1:0] e_exc,
                          logic [IDX_W-1:0] e_idx);
    resp_ready = 1'b1;
    cyc();
    drive(1'b1, va, st, asid);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 8'h0);
    #1;
    check({name, "_lat_valid0"}, 64'(resp_valid), 64'd0);
    cyc();
    #1;
    check({name, "_valid"}, 64'(resp_valid), 64'd1);
    check({name, "_paddr"}, 64'(resp_paddr), 64'(e_paddr));
    check({name, "_cached"}, 64'(resp_cached), 64'(e_cached));
    check({name, "_exc"}, 64'(resp_exc), 64'(e_exc));
    check({name, "_bad"}, 64'(resp_bad_vaddr), 64'(va));
    check({name, "_idx"}, 64'(resp_tlb_index), 64'(e_idx));
    $display("txn %s vaddr=%08h paddr=%08h cached=%0d exc=%0d idx=%0d", name, va,
             resp_paddr, resp_cached, resp_exc, resp_tlb_index);
  endtask

  function automatic logic [31:0] rand_vaddr();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return {3'b100, 29'($urandom)};
    if (r == 1) return {3'b101, 29'($urandom)};
    if (r == 2) return $urandom;
    return {19'($urandom_range(0, 23)), 13'($urandom)};
  endfunction

  function automatic tb_ent_t rand_ent();
    tb_ent_t e;
    e.present = ($urandom_range(0, 3) != 0);
    e.vpn = 19'($urandom_range(0, 23));
    e.asid = ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h22;
    for (int p = 0; p < 2; p++) begin
      e.page[p] = '{page_frame_number: 20'($urandom), is_cached: 3'($urandom),
                    is_dirty: 1'($urandom), is_valid: ($urandom_range(0, 4) != 0)};
    end
    return e;
  endfunction

  initial begin
    for (int i = 0; i < TLB_NUM; i++) tbl[i] = '0;
    tbl[5] = '{present: 1'b1, vpn: 19'h00201, asid: 8'h11,
               page: {tlb_entry_t'{20'h12345, 3'd3, 1'b0, 1'b1},
                      tlb_entry_t'{20'h0ABCD, 3'd3, 1'b1, 1'b0}}};
    tbl[6] = '{present: 1'b1, vpn: 19'h00300, asid: 8'h11,
               page: {tlb_entry_t'{20'h54321, 3'd2, 1'b1, 1'b1},
                      tlb_entry_t'{20'h00000, 3'd0, 1'b0, 1'b0}}};

    // Reset
    #1 reset_n = 1'b0;
    cyc();
    cyc();
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_paddr", 64'(resp_paddr), 64'd0);
    check("rst_bad", 64'(resp_bad_vaddr), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_search_request", 64'(search_request), 64'd0);
    cyc();
    reset_n = 1'b1;

    // kseg bypass, back to back
    resp_ready = 1'b1;
    cyc();
    drive(1'b1, 32'h8000_1234, 1'b0, 8'h0);
    cyc();
    drive(1'b1, 32'hA000_1234, 1'b0, 8'h0);
    #1;
    check("kseg_lat_valid0", 64'(resp_valid), 64'd0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 8'h0);
    #1;
    check("kseg0_valid", 64'(resp_valid), 64'd1);
    check("kseg0_paddr", 64'(resp_paddr), 64'h0000_1234);
    check("kseg0_cached", 64'(resp_cached), 64'd3);
    check("kseg0_exc", 64'(resp_exc), 64'd0);
    $display("txn kseg0 paddr=%08h cached=%0d", resp_paddr, resp_cached);
    cyc();
    #1;
    check("kseg1_valid", 64'(resp_valid), 64'd1);
    check("kseg1_paddr", 64'(resp_paddr), 64'h0000_1234);
    check("kseg1_cached", 64'(resp_cached), 64'd2);
    check("kseg1_exc", 64'(resp_exc), 64'd0);
    $display("txn kseg1 paddr=%08h cached=%0d", resp_paddr, resp_cached);

    // Mapped translations and exceptions
    send_one("odd_hit", 32'h0040_3ABC, 1'b0, 8'h11, 32'h1234_5ABC, 3'd3, 2'd0, 4'd5);
    check("odd_hit_vpn", 64'(search_request.virtual_page_number), 64'h00201);
    check("odd_hit_even", 64'(search_request.is_even_page), 64'd0);
    send_one("miss", 32'h7FFF_F000, 1'b0, 8'h11, 32'h0, 3'd0, 2'd1, 4'd0);
    send_one("invalid", 32'h0040_2010, 1'b0, 8'h11, 32'h0, 3'd0, 2'd2, 4'd5);
    send_one("modified", 32'h0040_3ABC, 1'b1, 8'h11, 32'h0, 3'd0, 2'd3, 4'd5);
    send_one("store_dirty", 32'h0060_1008, 1'b1, 8'h11, 32'h5432_1008, 3'd2, 2'd0, 4'd6);

    // Backpressure: three offers with resp_ready low
    cyc();
    resp_ready = 1'b0;
    drive(1'b1, 32'h8000_0100, 1'b0, 8'h0);
    #1 check("bp_ready_a", 64'(req_ready), 64'd1);
    cyc();
    drive(1'b1, 32'h8000_0200, 1'b0, 8'h0);
    #1 check("bp_ready_b", 64'(req_ready), 64'd1);
    cyc();
    drive(1'b1, 32'h8000_0300, 1'b0, 8'h0);
    #1;
    check("bp_ready_c", 64'(req_ready), 64'd0);
    check("bp_hold_paddr_c", 64'(resp_paddr), 64'h0000_0100);
    check("bp_hold_sreq_c", 64'(search_request.virtual_page_number), 64'h40000);
    cyc();
    resp_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 8'h0);
    #1;
    check("bp_hold_valid_d", 64'(resp_valid), 64'd1);
    check("bp_hold_paddr_d", 64'(resp_paddr), 64'h0000_0100);
    check("bp_hold_sreq_d", 64'(search_request.virtual_page_number), 64'h40000);
    $display("txn bp_first paddr=%08h", resp_paddr);
    cyc();
    #1;
    check("bp_second_valid", 64'(resp_valid), 64'd1);
    check("bp_second_paddr", 64'(resp_paddr), 64'h0000_0200);
    $display("txn bp_second paddr=%08h", resp_paddr);
    cyc();
    #1 check("bp_drained", 64'(resp_valid), 64'd0);

    // Flush with full pipe
    resp_ready = 1'b0;
    drive(1'b1, 32'h8000_0400, 1'b0, 8'h0);
    cyc();
    drive(1'b1, 32'h8000_0500, 1'b0, 8'h0);
    cyc();
    drive(1'b1, 32'h8000_0600, 1'b0, 8'h0);
    flush = 1'b1;
    #1 check("flush_req_ready", 64'(req_ready), 64'd0);
    cyc();
    flush = 1'b0;
    resp_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 8'h0);
    #1 check("flush_valid_1", 64'(resp_valid), 64'd0);
    cyc();
    #1 check("flush_valid_2", 64'(resp_valid), 64'd0);
    send_one("post_flush", 32'h8000_0700, 1'b0, 8'h0, 32'h0000_0700, 3'd3, 2'd0, 4'd0);

    // Asynchronous reset with full pipe
    cyc();
    resp_ready = 1'b0;
    drive(1'b1, 32'h0040_3ABC, 1'b0, 8'h11);
    cyc();
    drive(1'b1, 32'h8000_0800, 1'b0, 8'h0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 8'h0);
    #3 reset_n = 1'b0;
    #1;
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_paddr", 64'(resp_paddr), 64'd0);
    check("arst_bad", 64'(resp_bad_vaddr), 64'd0);
    check("arst_idx", 64'(resp_tlb_index), 64'd0);
    check("arst_sreq", 64'(search_request), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    cyc();
    #3 reset_n = 1'b1;
    resp_ready = 1'b1;
    cyc();
    #1 check("arst_no_stale_1", 64'(resp_valid), 64'd0);
    cyc();
    #1 check("arst_no_stale_2", 64'(resp_valid), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < TLB_NUM; i++) tbl[i] = rand_ent();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (n == 1500) begin
        #3 reset_n = 1'b0;
        cyc();
        #3 reset_n = 1'b1;
        cyc();
      end
      drive(($urandom_range(0, 3) != 0), rand_vaddr(), 1'($urandom),
            ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h22);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) tbl[$urandom_range(0, TLB_NUM - 1)] = rand_ent();
    end
    cyc();
    drive(1'b0, 32'h0, 1'b0, 8'h0);
    flush = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
